// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: credits nickels/dimes/quarters, vends priced items,
// shows reject indications and pays change one nickel per cycle.
module vend_ctrl #(
    parameter int NUM_ITEMS  = 16,
    parameter int BAL_W      = 6,
    parameter int MAX_BAL    = 40,
    parameter int PRICE_BASE = 5,
    parameter int PRICE_STEP = 5,
    parameter int DISP_CYC   = 4,
    parameter int REJ_CYC    = 3
) (
    input  logic                         hz100,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_val,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
    input  logic                         refund_req,
    output logic [BAL_W-1:0]             balance,
    output logic [2:0]                   state,
    output logic                         dispense,
    output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
    output logic                         reject,
    output logic                         change,
    output logic                         coin_return
);

    localparam int IDX_W   = $clog2(NUM_ITEMS);
    localparam int CNT_MAX = (DISP_CYC > REJ_CYC) ? DISP_CYC : REJ_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Headroom so balance+coin and price comparisons never overflow.
    localparam int SUM_W   = BAL_W + 4;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_MONEY     = 3'd1,
        ST_PURCHASED = 3'd2,
        ST_REJECTION = 3'd3,
        ST_REFUND    = 3'd4
    } state_e;

    function automatic logic [SUM_W-1:0] coin_nickels(input logic [1:0] cv);
        logic [SUM_W-1:0] n;
        case (cv)
            2'd0:    n = SUM_W'(3'd1);
            2'd1:    n = SUM_W'(3'd2);
            2'd2:    n = SUM_W'(3'd5);
            default: n = {SUM_W{1'b0}};
        endcase
        return n;
    endfunction

    // Price class is the item index modulo 4 (the low two bits).
    function automatic logic [SUM_W-1:0] price_of(input logic [IDX_W-1:0] idx);
        logic [1:0] cls;
        cls = 2'(idx);
        return SUM_W'(PRICE_BASE) + SUM_W'(cls) * SUM_W'(PRICE_STEP);
    endfunction

    state_e             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dispense_q, dispense_d;
    logic [IDX_W-1:0]   item_q, item_d;
    logic               reject_q, reject_d;
    logic               change_q, change_d;
    logic               coin_return_q, coin_return_d;

    logic [SUM_W-1:0]   sum_s;
    logic [SUM_W-1:0]   price_s;
    logic               coin_ok_s;
    logic               afford_s;

    assign sum_s     = SUM_W'(balance_q) + coin_nickels(coin_val);
    assign price_s   = price_of(sel_item);
    assign coin_ok_s = (coin_val != 2'd3) && (sum_s <= SUM_W'(MAX_BAL));
    assign afford_s  = (32'(sel_item) < NUM_ITEMS) && (SUM_W'(balance_q) >= price_s);

    // Next-state and next-output computation for the controller.
    always_comb begin
        state_d       = state_q;
        balance_d     = balance_q;
        cnt_d         = cnt_q;
        dispense_d    = dispense_q;
        item_d        = item_q;
        reject_d      = reject_q;
        change_d      = change_q;
        coin_return_d = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (sel_valid) begin
                    state_d       = ST_REJECTION;
                    reject_d      = 1'b1;
                    cnt_d         = {CNT_W{1'b0}};
                    coin_return_d = coin_valid;
                end else if (coin_valid) begin
                    if (coin_ok_s) begin
                        balance_d = BAL_W'(sum_s);
                        state_d   = ST_MONEY;
                    end else begin
                        coin_return_d = 1'b1;
                    end
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_MONEY: begin
                if (refund_req) begin
                    state_d       = ST_REFUND;
                    change_d      = (balance_q != {BAL_W{1'b0}});
                    coin_return_d = coin_valid;
                end else if (sel_valid) begin
                    coin_return_d = coin_valid;
                    cnt_d         = {CNT_W{1'b0}};
                    if (afford_s) begin
                        balance_d  = balance_q - BAL_W'(price_s);
                        item_d     = sel_item;
                        dispense_d = 1'b1;
                        state_d    = ST_PURCHASED;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = ST_REJECTION;
                    end
                end else if (coin_valid) begin
                    if (coin_ok_s) begin
                        balance_d = BAL_W'(sum_s);
                    end else begin
                        coin_return_d = 1'b1;
                    end
                end else begin
                    state_d = ST_MONEY;
                end
            end
            ST_PURCHASED: begin
                coin_return_d = coin_valid;
                if (cnt_q == CNT_W'(DISP_CYC - 1)) begin
                    dispense_d = 1'b0;
                    cnt_d      = {CNT_W{1'b0}};
                    if (balance_q != {BAL_W{1'b0}}) begin
                        state_d  = ST_REFUND;
                        change_d = 1'b1;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_REJECTION: begin
                coin_return_d = coin_valid;
                if (cnt_q == CNT_W'(REJ_CYC - 1)) begin
                    reject_d = 1'b0;
                    cnt_d    = {CNT_W{1'b0}};
                    if (balance_q != {BAL_W{1'b0}}) begin
                        state_d = ST_MONEY;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_REFUND: begin
                // change is already high for the cycle that shows the current balance.
                coin_return_d = coin_valid;
                if (balance_q > BAL_W'(1'b1)) begin
                    balance_d = balance_q - BAL_W'(1'b1);
                    change_d  = 1'b1;
                end else begin
                    balance_d = {BAL_W{1'b0}};
                    change_d  = 1'b0;
                    state_d   = ST_INIT;
                end
            end
            default: begin
                state_d    = ST_INIT;
                balance_d  = {BAL_W{1'b0}};
                cnt_d      = {CNT_W{1'b0}};
                dispense_d = 1'b0;
                item_d     = {IDX_W{1'b0}};
                reject_d   = 1'b0;
                change_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q       <= ST_INIT;
            balance_q     <= {BAL_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            dispense_q    <= 1'b0;
            item_q        <= {IDX_W{1'b0}};
            reject_q      <= 1'b0;
            change_q      <= 1'b0;
            coin_return_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            cnt_q         <= cnt_d;
            dispense_q    <= dispense_d;
            item_q        <= item_d;
            reject_q      <= reject_d;
            change_q      <= change_d;
            coin_return_q <= coin_return_d;
        end
    end

    assign state         = state_q;
    assign balance       = balance_q;
    assign dispense      = dispense_q;
    assign dispense_item = item_q;
    assign reject        = reject_q;
    assign change        = change_q;
    assign coin_return   = coin_return_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: directed stimulus pushes the hand-computed output
// snapshot expected after each clock; a monitor pops and compares every cycle.
module tb_vend_ctrl;

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_MON  = 3'd1;
    localparam logic [2:0] S_PUR  = 3'd2;
    localparam logic [2:0] S_REJ  = 3'd3;
    localparam logic [2:0] S_REF  = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] bal;
        logic       disp;
        logic [3:0] item;
        logic       rej;
        logic       chg;
        logic       cret;
    } exp_t;

    logic       hz100 = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = 2'd0;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_item = 4'd0;
    logic       refund_req = 1'b0;
    logic [5:0] balance;
    logic [2:0] state;
    logic       dispense;
    logic [3:0] dispense_item;
    logic       reject;
    logic       change;
    logic       coin_return;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t e_m;
    exp_t got_m;

    vend_ctrl dut (
        .hz100(hz100), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_item(sel_item), .refund_req(refund_req),
        .balance(balance), .state(state), .dispense(dispense), .dispense_item(dispense_item),
        .reject(reject), .change(change), .coin_return(coin_return)
    );

    always #5 hz100 = ~hz100;

    function automatic exp_t ex(input logic [2:0] st, input int bal, input logic d,
                                input int it, input logic rj, input logic ch, input logic cr);
        exp_t e;
        e.st = st; e.bal = 6'(bal); e.disp = d; e.item = 4'(it);
        e.rej = rj; e.chg = ch; e.cret = cr;
        return e;
    endfunction

    task automatic tick(input exp_t e);
        @(posedge hz100);
        #1;
        reset = 1'b0; coin_valid = 1'b0; sel_valid = 1'b0; refund_req = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        tick(e);
    endtask

    task automatic coin(input logic [1:0] v, input exp_t e);
        coin_valid = 1'b1; coin_val = v;
        tick(e);
    endtask

    task automatic sel(input int i, input exp_t e);
        sel_valid = 1'b1; sel_item = 4'(i);
        tick(e);
    endtask

    // Monitor: registered outputs are compared once per cycle against the scoreboard.
    always @(negedge hz100) begin
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            got_m = '{state, balance, dispense, dispense_item, reject, change, coin_return};
            checks++;
            if (got_m !== e_m) begin
                failures++;
                $display("FAIL cyc%0d outputs got st=%0d bal=%0d disp=%0b item=%0d rej=%0b chg=%0b cret=%0b required st=%0d bal=%0d disp=%0b item=%0d rej=%0b chg=%0b cret=%0b",
                         cyc, got_m.st, got_m.bal, got_m.disp, got_m.item, got_m.rej, got_m.chg, got_m.cret,
                         e_m.st, e_m.bal, e_m.disp, e_m.item, e_m.rej, e_m.chg, e_m.cret);
            end
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, including a coin coincident with reset that must be ignored.
        coin_valid = 1'b1; coin_val = 2'd2;
        tick(ex(S_INIT, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        tick(ex(S_INIT, 0, 0, 0, 0, 0, 0));
        refund_req = 1'b1;
        tick(ex(S_INIT, 0, 0, 0, 0, 0, 0));
        coin(2'd3, ex(S_INIT, 0, 0, 0, 0, 0, 1));
        // Selection with no credit is rejected for three cycles.
        sel(5, ex(S_REJ, 0, 0, 0, 1, 0, 0));
        idle(ex(S_REJ, 0, 0, 0, 1, 0, 0));
        idle(ex(S_REJ, 0, 0, 0, 1, 0, 0));
        idle(ex(S_INIT, 0, 0, 0, 0, 0, 0));

        // Quarter, quarter, item 1 (price 10): exact purchase, no change.
        coin(2'd2, ex(S_MON, 5, 0, 0, 0, 0, 0));
        coin(2'd2, ex(S_MON, 10, 0, 0, 0, 0, 0));
        sel(1, ex(S_PUR, 0, 1, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++) idle(ex(S_PUR, 0, 1, 1, 0, 0, 0));
        idle(ex(S_INIT, 0, 0, 1, 0, 0, 0));
        idle(ex(S_INIT, 0, 0, 1, 0, 0, 0));

        // Quarter, dime, item 2 (price 15): rejected, balance kept.
        coin(2'd2, ex(S_MON, 5, 0, 1, 0, 0, 0));
        coin(2'd1, ex(S_MON, 7, 0, 1, 0, 0, 0));
        sel(2, ex(S_REJ, 7, 0, 1, 1, 0, 0));
        idle(ex(S_REJ, 7, 0, 1, 1, 0, 0));
        idle(ex(S_REJ, 7, 0, 1, 1, 0, 0));
        idle(ex(S_MON, 7, 0, 1, 0, 0, 0));

        // Item 0 (price 5) from 7: vend then two change cycles.
        sel(0, ex(S_PUR, 2, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) idle(ex(S_PUR, 2, 1, 0, 0, 0, 0));
        idle(ex(S_REF, 2, 0, 0, 0, 1, 0));
        idle(ex(S_REF, 1, 0, 0, 0, 1, 0));
        idle(ex(S_INIT, 0, 0, 0, 0, 0, 0));
        idle(ex(S_INIT, 0, 0, 0, 0, 0, 0));

        // Fill to MAX_BAL, then an overflowing quarter and a slug bounce.
        for (int k = 1; k <= 8; k++) coin(2'd2, ex(S_MON, 5 * k, 0, 0, 0, 0, 0));
        coin(2'd2, ex(S_MON, 40, 0, 0, 0, 0, 1));
        coin(2'd3, ex(S_MON, 40, 0, 0, 0, 0, 1));
        idle(ex(S_MON, 40, 0, 0, 0, 0, 0));
        // Selection beats a same-cycle coin: item 3 costs 20.
        coin_valid = 1'b1; coin_val = 2'd0;
        sel(3, ex(S_PUR, 20, 1, 3, 0, 0, 1));
        coin(2'd1, ex(S_PUR, 20, 1, 3, 0, 0, 1));
        idle(ex(S_PUR, 20, 1, 3, 0, 0, 0));
        sel(0, ex(S_PUR, 20, 1, 3, 0, 0, 0));
        idle(ex(S_REF, 20, 0, 3, 0, 1, 0));
        refund_req = 1'b1;
        coin(2'd0, ex(S_REF, 19, 0, 3, 0, 1, 1));
        for (int b = 18; b >= 1; b--) idle(ex(S_REF, b, 0, 3, 0, 1, 0));
        idle(ex(S_INIT, 0, 0, 3, 0, 0, 0));

        // Balance 3, refund beats same-cycle select and coin; reset mid-refund.
        coin(2'd1, ex(S_MON, 2, 0, 3, 0, 0, 0));
        coin(2'd0, ex(S_MON, 3, 0, 3, 0, 0, 0));
        refund_req = 1'b1; sel_valid = 1'b1; sel_item = 4'd0;
        coin(2'd0, ex(S_REF, 3, 0, 3, 0, 1, 1));
        idle(ex(S_REF, 2, 0, 3, 0, 1, 0));
        reset = 1'b1;
        tick(ex(S_INIT, 0, 0, 0, 0, 0, 0));

        // Reset mid-vend of item 4 (price class 0).
        coin(2'd2, ex(S_MON, 5, 0, 0, 0, 0, 0));
        sel(4, ex(S_PUR, 0, 1, 4, 0, 0, 0));
        idle(ex(S_PUR, 0, 1, 4, 0, 0, 0));
        reset = 1'b1;
        tick(ex(S_INIT, 0, 0, 0, 0, 0, 0));
        idle(ex(S_INIT, 0, 0, 0, 0, 0, 0));

        @(negedge hz100);
        @(negedge hz100);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 16: number of selectable items.
REQ-002 SHALL have parameter BAL_W, default 6: balance width in nickels.
REQ-003 SHALL have parameter MAX_BAL, default 40: max balance in nickels, at most 2**BAL_W-1.
REQ-004 SHALL have parameter PRICE_BASE, default 5: price of price-class 0, in nickels.
REQ-005 SHALL have parameter PRICE_STEP, default 5: price increment per price class, in nickels.
REQ-006 SHALL have parameter DISP_CYC, default 4: dispense duration in cycles.
REQ-007 SHALL have parameter REJ_CYC, default 3: reject-indication duration in cycles.
REQ-008 SHALL have port hz100, input, 1: the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-010 SHALL have port coin_valid, input, 1: one-cycle coin strobe.
REQ-011 SHALL have port coin_val, input, 2: 0=nickel(1), 1=dime(2), 2=quarter(5), 3=invalid slug.
REQ-012 SHALL have port sel_valid, input, 1: one-cycle selection strobe.
REQ-013 SHALL have port sel_item, input, $clog2(NUM_ITEMS): selected item index.
REQ-014 SHALL have port refund_req, input, 1: one-cycle refund request.
REQ-015 SHALL have port balance, output, BAL_W: current credit in nickels (registered).
REQ-016 SHALL have port state, output, 3: INIT=0, MONEY=1, PURCHASED=2, REJECTION=3, REFUND=4 (registered).
REQ-017 SHALL have ports dispense (output, 1) and dispense_item (output, $clog2(NUM_ITEMS)): active vend and its latched item.
REQ-018 SHALL have ports reject (output, 1), change (output, 1: one nickel returned per asserted cycle) and coin_return (output, 1: one-cycle pulse, coin bounced).

Function
REQ-019 SHALL compute price(i) = PRICE_BASE + (i mod 4)*PRICE_STEP nickels; defaults give 5/10/15/20.
REQ-020 SHALL register all state changes, so outputs respond one cycle after the input strobe.
REQ-021 INIT: a valid coin SHALL add its value and go to MONEY. sel_valid SHALL go to REJECTION. refund_req SHALL be ignored.
REQ-022 MONEY: a valid coin SHALL add its value to balance and stay in MONEY.
REQ-023 MONEY, sel_valid: if sel_item<NUM_ITEMS and balance>=price, SHALL subtract price, latch dispense_item and go to PURCHASED; otherwise SHALL go to REJECTION with balance unchanged.
REQ-024 MONEY, refund_req: SHALL go to REFUND.
REQ-025 Same-cycle priority in MONEY SHALL be refund_req > sel_valid > coin_valid; a coin losing priority SHALL pulse coin_return and not be credited.
REQ-026 coin_val=3, or a coin making balance exceed MAX_BAL, SHALL pulse coin_return next cycle; balance unchanged.
REQ-027 Coins arriving in PURCHASED, REJECTION or REFUND SHALL pulse coin_return and not be credited; sel_valid and refund_req there SHALL be ignored.
REQ-028 dispense SHALL be high exactly DISP_CYC cycles (all of PURCHASED); then go to REFUND if balance>0, else INIT.
REQ-029 reject SHALL be high exactly REJ_CYC cycles (all of REJECTION); then go to MONEY if balance>0, else INIT.
REQ-030 REFUND: change SHALL be high every cycle, balance decrementing by 1 per cycle; when balance reaches 0, SHALL go to INIT, with change low from then on.
REQ-031 Balance arithmetic SHALL never wrap; balance stays within 0..MAX_BAL.

Reset
REQ-032 reset high at a clock edge SHALL force state=INIT, balance=0 and all of dispense, dispense_item, reject, change, coin_return and internal counters to 0, from any state including mid-REFUND or mid-PURCHASED.
REQ-033 Inputs coincident with reset SHALL be ignored.

Verification (defaults)
REQ-034 Quarter, quarter, then sel_item=1 -> balance 10 then 0; dispense high 4 cycles, dispense_item=1; then INIT, change never high.
REQ-035 Quarter, dime (balance 7), sel_item=2 -> reject high 3 cycles, balance stays 7, returns to MONEY.
REQ-036 Balance 7, sel_item=0 -> balance 2, dispense 4 cycles, then REFUND with exactly 2 change cycles, then INIT with balance 0.
REQ-037 8 quarters (balance 40), a 9th quarter, then a slug -> two coin_return pulses, balance stays 40. Same-cycle sel_valid+coin -> coin_return, purchase proceeds.
REQ-038 Balance 3, refund_req, then reset asserted on the 2nd REFUND cycle -> next cycle state=INIT, balance=0, change=0.
